// File: rtl/nibble_packer.sv
// Packs a 4-bit nibble stream into bytes, high nibble first, and queues them in a small FIFO.
// Optional macro PACK_BIT_REVERSE_EN stores each byte bit-reversed.
module nibble_packer #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_nibble,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [7:0]                    out_byte,
    output logic                          out_partial,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic {StEmpty, StHalf} state_e;

    state_e            state_q, state_d;
    logic [3:0]        hi_q, hi_d;
    logic              push, pop;
    logic [7:0]        asm_byte;
    logic [7:0]        store_byte;
    logic              asm_partial;

    logic [8:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [8:0]        last_q;
    logic [8:0]        head;

    assign in_ready   = (count_q != CntW'(FIFO_DEPTH));
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    assign fill_level = count_q;

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        push        = 1'b0;
        asm_byte    = 8'h00;
        asm_partial = 1'b0;
        if (in_valid && in_ready) begin
            unique case (state_q)
                StEmpty: begin
                    if (in_last) begin
                        push        = 1'b1;
                        asm_byte    = {in_nibble, 4'h0};
                        asm_partial = 1'b1;
                    end else begin
                        hi_d    = in_nibble;
                        state_d = StHalf;
                    end
                end
                StHalf: begin
                    push     = 1'b1;
                    asm_byte = {hi_q, in_nibble};
                    state_d  = StEmpty;
                end
            endcase
        end
    end

`ifdef PACK_BIT_REVERSE_EN
    always_comb begin
        store_byte = 8'h00;
        for (int i = 0; i < 8; i++) begin
            store_byte[i] = asm_byte[7-i];
        end
    end
`else
    assign store_byte = asm_byte;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            hi_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
        end
    end

    // in_ready already excludes a push into a full FIFO, so no overflow guard is needed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 9'h000;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= 9'h000;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {asm_partial, store_byte};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                last_q   <= mem_q[rd_ptr_q];
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Hold the most recently read entry while empty so the outputs never go undefined
    assign head        = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign out_byte    = head[7:0];
    assign out_partial = head[8];

endmodule

// File: tb/tb_nibble_packer.sv
// Directed self-checking bench for nibble_packer (FIFO_DEPTH = 2).
module tb_nibble_packer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_nibble;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_partial;
    logic [1:0] fill_level;

    int checks = 0;
    int errors = 0;
    logic [8:0] got_q[$];

    nibble_packer #(.FIFO_DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_nibble  (in_nibble),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_partial(out_partial),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every popped entry as {partial, byte}
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({out_partial, out_byte});
    end

    function automatic logic [7:0] exp_byte(input logic [7:0] b);
        logic [7:0] r;
`ifdef PACK_BIT_REVERSE_EN
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
`else
        r = b;
`endif
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the handshake edge
    task automatic send(input logic [3:0] n, input logic last);
        int waited = 0;
        in_valid  = 1'b1;
        in_nibble = n;
        in_last   = last;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check_eq("send_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_nibble = 4'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_byte", 32'(out_byte), 32'h00);
        check_eq("rst_out_partial", 32'(out_partial), 32'd0);
        check_eq("rst_fill", 32'(fill_level), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Basic pair
        out_ready = 1'b1;
        send(4'hA, 1'b0);
        check_eq("pair_valid_early", 32'(out_valid), 32'd0);
        send(4'h5, 1'b0);
        check_eq("pair_valid", 32'(out_valid), 32'd1);
        check_eq("pair_byte", 32'(out_byte), 32'(exp_byte(8'hA5)));
        check_eq("pair_partial", 32'(out_partial), 32'd0);
        idle(2);

        // Flush from EMPTY, then confirm the FSM stayed EMPTY
        send(4'h3, 1'b1);
        check_eq("flush_e_byte", 32'(out_byte), 32'(exp_byte(8'h30)));
        check_eq("flush_e_partial", 32'(out_partial), 32'd1);
        check_eq("flush_e_fill", 32'(fill_level), 32'd1);
        send(4'h4, 1'b0);
        send(4'h6, 1'b0);
        check_eq("after_flush_byte", 32'(out_byte), 32'(exp_byte(8'h46)));
        idle(2);

        // Flush from HALF
        send(4'h7, 1'b0);
        send(4'h8, 1'b1);
        check_eq("flush_h_byte", 32'(out_byte), 32'(exp_byte(8'h78)));
        check_eq("flush_h_partial", 32'(out_partial), 32'd0);
        send(4'h9, 1'b1);
        check_eq("flush_h2_byte", 32'(out_byte), 32'(exp_byte(8'h90)));
        check_eq("flush_h2_partial", 32'(out_partial), 32'd1);
        idle(2);

        // Backpressure
        out_ready = 1'b0;
        got_q.delete();
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        check_eq("bp_ready_mid", 32'(in_ready), 32'd1);
        send(4'h4, 1'b0);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        check_eq("bp_fill", 32'(fill_level), 32'd2);
        idle(2);
        check_eq("bp_hold_fill", 32'(fill_level), 32'd2);
        out_ready = 1'b1;
        send(4'h5, 1'b0);
        send(4'h6, 1'b0);
        idle(4);
        check_eq("bp_count", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check_eq("bp_0", 32'(got_q[0]), 32'({1'b0, exp_byte(8'h12)}));
            check_eq("bp_1", 32'(got_q[1]), 32'({1'b0, exp_byte(8'h34)}));
            check_eq("bp_2", 32'(got_q[2]), 32'({1'b0, exp_byte(8'h56)}));
        end
        check_eq("empty_valid", 32'(out_valid), 32'd0);
        check_eq("empty_last_read", 32'(out_byte), 32'(exp_byte(8'h56)));

        // Reset mid-operation with FIFO contents and a held high nibble
        out_ready = 1'b0;
        send(4'hA, 1'b0);
        send(4'hB, 1'b0);
        send(4'hF, 1'b0);
        check_eq("pre_rst_fill", 32'(fill_level), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_fill", 32'(fill_level), 32'd0);
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_byte", 32'(out_byte), 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        out_ready = 1'b1;
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        idle(3);
        check_eq("post_rst_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) begin
            check_eq("post_rst_byte", 32'(got_q[0]), 32'({1'b0, exp_byte(8'h12)}));
        end

`ifdef PACK_BIT_REVERSE_EN
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        check_eq("rev_byte", 32'(out_byte), 32'h48);
        send(4'h3, 1'b1);
        check_eq("rev_partial_byte", 32'(out_byte), 32'h0C);
        check_eq("rev_partial_flag", 32'(out_partial), 32'd1);
        idle(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
